// File: rtl/pkt_rr_arbiter_if.sv
// Packet-stream bundle between NUM_IN requesters, the arbiter and the shared downstream FIFO.
// The slave modport is the arbiter's view; master is the requester/FIFO side.
interface pkt_rr_arbiter_if #(
    parameter int NUM_IN = 4,
    parameter int DWIDTH = 512
);
    logic [NUM_IN*DWIDTH-1:0] in_data;
    logic [NUM_IN-1:0]        in_valid;
    logic [NUM_IN-1:0]        in_eop;
    logic [NUM_IN-1:0]        in_ready;
    logic [DWIDTH-1:0]        out_data;
    logic                     out_valid;
    logic                     out_eop;
    logic                     out_ready;

    modport slave (
        input  in_data, in_valid, in_eop, out_ready,
        output in_ready, out_data, out_valid, out_eop
    );

    modport master (
        output in_data, in_valid, in_eop, out_ready,
        input  in_ready, out_data, out_valid, out_eop
    );
endinterface

// File: rtl/pkt_rr_arbiter.sv
// Packet-granular round-robin arbiter in front of a shared FIFO, with an in-flight word
// counter that stops new grants once the FIFO is near full.
module pkt_rr_arbiter #(
    parameter int NUM_IN     = 4,
    parameter int DWIDTH     = 512,
    parameter int FULL_LEVEL = 490,
    parameter int CWIDTH     = $clog2(FULL_LEVEL) + 2,
    localparam int GW        = $clog2(NUM_IN)
) (
    input  logic                  clk,
    input  logic                  rst,
    pkt_rr_arbiter_if.slave       bus,
    input  logic                  deq,
    output logic [CWIDTH-1:0]     occupancy,
    output logic                  almost_full,
    output logic [GW-1:0]         grant_id,
    output logic                  busy
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [GW-1:0]     grant_nxt;
    logic              push;
    logic              pop;
    logic [DWIDTH-1:0] in_words [NUM_IN];

    for (genvar i = 0; i < NUM_IN; i++) begin : g_unpack
        assign in_words[i] = bus.in_data[i*DWIDTH +: DWIDTH];
    end

    // First requesting index after 'last', wrapping; 'last' itself is checked last.
    function automatic logic [GW-1:0] rr_pick(input logic [GW-1:0] last,
                                              input logic [NUM_IN-1:0] req);
        logic [GW-1:0] pick;
        logic          found;
        int            idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= NUM_IN; k++) begin
            idx = (int'(last) + k) % NUM_IN;
            if (!found && req[idx]) begin
                pick  = GW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        bus.in_ready  = '0;
        bus.out_valid = 1'b0;
        bus.out_eop   = 1'b0;
        bus.out_data  = in_words[grant_id];
        if (state == BUSY) begin
            bus.out_valid          = bus.in_valid[grant_id];
            bus.out_eop            = bus.in_eop[grant_id];
            bus.in_ready[grant_id] = bus.out_ready;
        end
    end

    assign push = bus.out_valid & bus.out_ready;
    assign pop  = deq & (occupancy != '0);

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_id;
        case (state)
            IDLE: begin
                if (!almost_full && (|bus.in_valid)) begin
                    state_nxt = BUSY;
                    grant_nxt = rr_pick(grant_id, bus.in_valid);
                end
            end
            BUSY: begin
                if (push && bus.out_eop) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // almost_full samples the pre-update occupancy, so it trails the counter by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant_id    <= GW'(NUM_IN - 1);
            busy        <= 1'b0;
            occupancy   <= '0;
            almost_full <= 1'b0;
        end else begin
            state       <= state_nxt;
            grant_id    <= grant_nxt;
            busy        <= (state_nxt == BUSY);
            almost_full <= (occupancy >= CWIDTH'(FULL_LEVEL));
            if (push && !pop) begin
                occupancy <= occupancy + 1'b1;
            end else if (pop && !push) begin
                occupancy <= occupancy - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// Directed bench for pkt_rr_arbiter: packet sources, a behavioural arbiter/occupancy model
// compared every cycle, and literal expectations for the key scenarios.
module tb_pkt_rr_arbiter;
    localparam int NUM_IN = 4;
    localparam int DW     = 32;
    localparam int FULL   = 8;
    localparam int CW     = $clog2(FULL) + 2;
    localparam int GW     = $clog2(NUM_IN);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          deq = 1'b0;
    logic [CW-1:0] occupancy;
    logic          almost_full;
    logic [GW-1:0] grant_id;
    logic          busy;

    pkt_rr_arbiter_if #(.NUM_IN(NUM_IN), .DWIDTH(DW)) bus ();

    pkt_rr_arbiter #(.NUM_IN(NUM_IN), .DWIDTH(DW), .FULL_LEVEL(FULL)) dut (
        .clk(clk), .rst(rst), .bus(bus), .deq(deq),
        .occupancy(occupancy), .almost_full(almost_full),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Behavioural model state: is a packet open, who owns it, words in flight, full flag.
    bit m_busy;
    int m_gid;
    int m_occ;
    bit m_af;
    logic [NUM_IN-1:0] m_in_ready;
    logic              m_out_valid;
    logic              m_out_eop;
    logic [DW-1:0]     m_out_data;

    // Packet sources: beats per packet, packets left, current beat, packet serial.
    int src_len  [NUM_IN];
    int src_npk  [NUM_IN];
    int src_beat [NUM_IN];
    int src_pk   [NUM_IN];

    int            grant_q[$];
    logic [DW-1:0] xfer_q[$];
    logic          busy_q = 1'b0;

    always_comb begin
        m_in_ready  = '0;
        m_out_valid = 1'b0;
        m_out_eop   = 1'b0;
        m_out_data  = '0;
        if (m_busy) begin
            m_in_ready[m_gid] = bus.out_ready;
            m_out_valid       = bus.in_valid[m_gid];
            m_out_eop         = bus.in_eop[m_gid];
            m_out_data        = bus.in_data[m_gid*DW +: DW];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready",    64'(bus.in_ready),  64'(m_in_ready));
            chk("out_valid",   64'(bus.out_valid), 64'(m_out_valid));
            chk("out_eop",     64'(bus.out_eop),   64'(m_out_eop));
            if (m_out_valid) chk("out_data", 64'(bus.out_data), 64'(m_out_data));
            chk("busy",        64'(busy),          64'(m_busy));
            chk("grant_id",    64'(grant_id),      64'(m_gid));
            chk("occupancy",   64'(occupancy),     64'(m_occ));
            chk("almost_full", 64'(almost_full),   64'(m_af));
            if (bus.out_valid && bus.out_ready) xfer_q.push_back(bus.out_data);
            if (busy && !busy_q) grant_q.push_back(int'(grant_id));
            busy_q <= busy;
        end
    end

    task automatic drive_inputs();
        for (int i = 0; i < NUM_IN; i++) begin
            bus.in_valid[i] = (src_npk[i] > 0);
            bus.in_eop[i]   = (src_beat[i] == src_len[i] - 1);
            bus.in_data[i*DW +: DW] = {8'(i), 8'(src_pk[i]), 16'(src_beat[i])};
        end
    endtask

    task automatic model_update();
        logic [NUM_IN-1:0] acc;
        logic push, pop, eop, next_af;
        bit   found;
        acc = '0;
        if (rst) begin
            m_busy = 1'b0;
            m_gid  = NUM_IN - 1;
            m_occ  = 0;
            m_af   = 1'b0;
        end else begin
            acc     = m_in_ready & bus.in_valid;
            push    = m_out_valid & bus.out_ready;
            eop     = m_out_eop;
            pop     = deq && (m_occ > 0);
            next_af = (m_occ >= FULL);
            if (!m_busy) begin
                if (!m_af && (|bus.in_valid)) begin
                    found = 1'b0;
                    for (int k = 1; k <= NUM_IN; k++) begin
                        if (!found && bus.in_valid[(m_gid + k) % NUM_IN]) begin
                            m_gid = (m_gid + k) % NUM_IN;
                            found = 1'b1;
                        end
                    end
                    m_busy = 1'b1;
                end
            end else if (push && eop) begin
                m_busy = 1'b0;
            end
            m_occ = m_occ + int'(push) - int'(pop);
            m_af  = next_af;
        end
        for (int i = 0; i < NUM_IN; i++) begin
            if (acc[i]) begin
                if (src_beat[i] == src_len[i] - 1) begin
                    src_beat[i] = 0;
                    src_npk[i]--;
                    src_pk[i]++;
                end else begin
                    src_beat[i]++;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_update();
        drive_inputs();
    endtask

    task automatic src_clear();
        for (int i = 0; i < NUM_IN; i++) begin
            src_len[i]  = 1;
            src_npk[i]  = 0;
            src_beat[i] = 0;
            src_pk[i]   = 0;
        end
    endtask

    task automatic load(input int i, input int len, input int npk);
        src_len[i]  = len;
        src_npk[i]  = npk;
        src_beat[i] = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        deq = 1'b0;
        bus.out_ready = 1'b1;
        src_clear();
        drive_inputs();
        step();
        chk_en = 1'b1;
        rst = 1'b0;
        xfer_q.delete();
        grant_q.delete();
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while ((busy || (|bus.in_valid)) && n < budget);
        if (busy || (|bus.in_valid)) begin
            n_run++;
            n_fail++;
            $display("FAIL idle_timeout: busy=%0b in_valid=%0b after %0d cycles", busy, bus.in_valid, n);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    int exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    initial begin
        bus.in_data  = '0;
        bus.in_valid = '0;
        bus.in_eop   = '0;
        bus.out_ready = 1'b1;

        // Reset state and a single 3-beat packet from requester 0.
        do_reset();
        chk("rst_grant_id",  64'(grant_id),      64'd3);
        chk("rst_occupancy", 64'(occupancy),     64'd0);
        chk("rst_af",        64'(almost_full),   64'd0);
        chk("rst_busy",      64'(busy),          64'd0);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_eop",   64'(bus.out_eop),   64'd0);
        load(0, 3, 1);
        drive_inputs();
        step();
        chk("t1_in_ready_c2", 64'(bus.in_ready), 64'h1);
        repeat (3) step();
        chk("t1_busy",     64'(busy),        64'd0);
        chk("t1_occ",      64'(occupancy),   64'd3);
        chk("t1_grant",    64'(grant_id),    64'd0);
        chk("t1_nbeats",   64'(xfer_q.size()), 64'd3);
        if (xfer_q.size() == 3) chk("t1_last_beat", 64'(xfer_q[2]), 64'h0000_0002);

        // All four requesters with back-to-back single-beat packets.
        do_reset();
        for (int i = 0; i < NUM_IN; i++) load(i, 1, 2);
        drive_inputs();
        repeat (16) step();
        chk("t2_ngrants", 64'(grant_q.size()), 64'd8);
        for (int k = 0; k < 8; k++) begin
            if (k < grant_q.size()) chk("t2_order", 64'(grant_q[k]), 64'(exp_order[k]));
        end
        chk("t2_occ",     64'(occupancy),    64'd8);
        chk("t2_drained", 64'(bus.in_valid), 64'd0);

        // Requester 2, 4-beat packet with out_ready toggling.
        do_reset();
        load(2, 4, 1);
        drive_inputs();
        step();
        chk("t3_grant", 64'(grant_id), 64'd2);
        for (int k = 0; k < 8; k++) begin
            bus.out_ready = (k % 2 == 0);
            chk("t3_others_ready", 64'(bus.in_ready & 4'b1011), 64'd0);
            step();
        end
        bus.out_ready = 1'b1;
        chk("t3_nbeats", 64'(xfer_q.size()), 64'd4);
        for (int b = 0; b < 4; b++) begin
            if (b < xfer_q.size()) chk("t3_beat", 64'(xfer_q[b]), 64'({8'd2, 8'd0, 16'(b)}));
        end
        chk("t3_busy", 64'(busy),      64'd0);
        chk("t3_occ",  64'(occupancy), 64'd4);

        // Fill to FULL_LEVEL, pending request blocked, released by one deq.
        do_reset();
        load(0, 8, 1);
        drive_inputs();
        run_until_idle(20);
        chk("t4_occ8", 64'(occupancy), 64'd8);
        repeat (2) step();
        chk("t4_af", 64'(almost_full), 64'd1);
        load(1, 1, 1);
        drive_inputs();
        repeat (3) step();
        chk("t4_blocked_busy", 64'(busy),      64'd0);
        chk("t4_blocked_occ",  64'(occupancy), 64'd8);
        deq = 1'b1;
        step();
        deq = 1'b0;
        chk("t4_deq_occ",  64'(occupancy),   64'd7);
        chk("t4_deq_af",   64'(almost_full), 64'd1);
        chk("t4_deq_busy", 64'(busy),        64'd0);
        step();
        chk("t4_af_clear", 64'(almost_full), 64'd0);
        chk("t4_not_yet",  64'(busy),        64'd0);
        step();
        chk("t4_grant_busy", 64'(busy),     64'd1);
        chk("t4_grant_id",   64'(grant_id), 64'd1);

        // Simultaneous push/pop holds; deq on empty does not underflow.
        do_reset();
        load(0, 5, 1);
        drive_inputs();
        run_until_idle(20);
        chk("t5_occ5", 64'(occupancy), 64'd5);
        load(0, 3, 1);
        drive_inputs();
        step();
        deq = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t5_hold", 64'(occupancy), 64'd5);
        end
        repeat (5) step();
        chk("t5_drained", 64'(occupancy), 64'd0);
        repeat (2) step();
        chk("t5_no_underflow", 64'(occupancy), 64'd0);
        deq = 1'b0;

        // Reset during beat 2 of a 5-beat packet.
        do_reset();
        load(0, 5, 1);
        drive_inputs();
        step();
        step();
        chk("t6_mid_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        step();
        chk("t6_busy",      64'(busy),          64'd0);
        chk("t6_occ",       64'(occupancy),     64'd0);
        chk("t6_out_valid", 64'(bus.out_valid), 64'd0);
        chk("t6_grant_id",  64'(grant_id),      64'd3);
        rst = 1'b0;
        src_clear();
        load(1, 1, 1);
        load(3, 1, 1);
        drive_inputs();
        step();
        chk("t6_next_busy",  64'(busy),     64'd1);
        chk("t6_next_grant", 64'(grant_id), 64'd1);
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/pkt_rr_arbiter.md
Name: pkt_rr_arbiter

Overview:
- Shares one downstream packet FIFO among NUM_IN packet-stream requesters.
- Round-robin arbitration on packet boundaries; a grant is held from the first beat to the eop beat.
- Tracks downstream occupancy internally with an in/out word counter.
- Blocks new packet grants while occupancy is at or above FULL_LEVEL.
- Sits in front of the shared FIFO feeding the downstream matcher/DMA stage.

Parameters:
- NUM_IN, 4, number of requesters (2..16).
- DWIDTH, 512, data width per beat.
- FULL_LEVEL, 490, occupancy in words at which new grants stop. Downstream FIFO depth must be at least FULL_LEVEL plus max packet words.
- CWIDTH, $clog2(FULL_LEVEL)+2, occupancy counter width (derived).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_data  in  NUM_IN*DWIDTH  requester data; requester i occupies bits [i*DWIDTH +: DWIDTH].
- in_valid  in  NUM_IN  requester beat valid.
- in_eop  in  NUM_IN  requester last beat of packet.
- in_ready  out  NUM_IN  requester beat accepted when in_valid[i]&in_ready[i].
- out_data  out  DWIDTH  data to downstream FIFO.
- out_valid  out  1  beat valid to downstream.
- out_eop  out  1  last beat of packet.
- out_ready  in  1  downstream can accept.
- deq  in  1  downstream consumed one word this cycle.
- occupancy  out  CWIDTH  current in-flight word count.
- almost_full  out  1  registered, occupancy >= FULL_LEVEL.
- grant_id  out  $clog2(NUM_IN)  index of current/last granted requester.
- busy  out  1  a packet is in progress.

Behaviour:
- Reset values: state=IDLE, grant_id=NUM_IN-1 (so requester 0 wins first), occupancy=0, almost_full=0, busy=0, in_ready=0, out_valid=0, out_eop=0.
  - Reset mid-packet abandons the packet. No partial beats are emitted after rst.
- FSM states: IDLE, BUSY.
- IDLE:
  - If almost_full==0 and |in_valid, pick the first i with in_valid[i], searching circularly from grant_id+1.
  - Register grant_id=i and busy=1, then go to BUSY.
  - No beat transfers in IDLE. Arbitration costs exactly 1 cycle.
  - If almost_full==1 or no valid, stay in IDLE.
- BUSY:
  - Datapath is combinational: out_valid=in_valid[grant_id], out_data=in_data[grant_id], out_eop=in_eop[grant_id].
  - in_ready[grant_id]=out_ready. All other in_ready bits are 0.
  - A beat transfers when out_valid&out_ready.
  - When a transferred beat has out_eop=1, go to IDLE next cycle (busy=0); grant_id is kept for the next RR search.
  - almost_full asserting mid-packet does NOT stall or cut the packet; it only blocks the next grant.
- Single-beat packet (sop=eop): IDLE, then BUSY for one transfer, then IDLE. Per requester this gives at most one packet every 2 cycles.
- Fairness: after a packet from requester k, the next search starts at k+1 mod NUM_IN. Wrap from NUM_IN-1 goes to 0.
- Occupancy counter, updated every cycle:
  - push = out_valid&out_ready.
  - pop = deq & (occupancy != 0); deq while occupancy==0 is ignored.
  - push & !pop: +1.
  - pop & !push: -1.
  - both or neither: hold.
- almost_full is registered from the current occupancy (occupancy >= FULL_LEVEL), so it lags occupancy by 1 cycle. The IDLE decision uses the registered value.
- Equality at FULL_LEVEL counts as full.
- No output depends combinationally on deq.

Test Plan:
- Reset then in_valid=4'b0001 with 3-beat packet, out_ready=1 -> in_ready[0] high from cycle 2; 3 beats out; out_eop on 3rd; busy drops next cycle; occupancy=3; grant_id=0.
- All 4 requesters hold 1-beat packets continuously, out_ready=1, deq=0 -> grant order 0,1,2,3,0,…; one packet per 2 cycles; occupancy increments by 1 per packet.
- Granted requester 2, out_ready toggling 1,0,1,0 during a 4-beat packet -> beats move only on out_ready=1 cycles; in_ready[0,1,3]=0 throughout; no beat lost or duplicated.
- FULL_LEVEL=8, push 8 words with deq=0 -> almost_full=1 one cycle after occupancy reaches 8; pending requester is not granted. Pulse deq once -> occupancy=7, almost_full=0 next cycle, grant issued the cycle after.
- occupancy=5, simultaneous push and deq for 3 cycles -> occupancy stays 5. deq with occupancy=0 -> occupancy stays 0 (no underflow to all ones).
- Assert rst during beat 2 of a 5-beat packet -> next cycle state IDLE, occupancy=0, out_valid=0, grant_id=NUM_IN-1. The next grant goes to the lowest valid index.
